intersection_request_scheduler: RTL and testbench

- Front-end scheduler for the traffic light controller.
- Synchronises and debounces raw requesters: secondary-road sensor, pedestrian buttons and emergency preempt.
- Latches each request as sticky pending and offers one service request at a time over a valid/ready handshake.
- Arbitration: preempt first, then round-robin, with a post-service hold-off so phases are not re-requested back to back.

---
 rtl/intersection_request_scheduler.sv | 147 ++++++++++++++
 tb/tb_intersection_request_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/intersection_request_scheduler.sv
// intersection_request_scheduler: conditions raw requests and offers one service at a time,
// preempt first then round-robin, with a hold-off after each completed service.
module intersection_request_scheduler #(
    parameter int NUM_REQ         = 4,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int HOLDOFF_CYCLES  = 200000
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_raw,
    input  logic                       preempt_raw,
    input  logic                       fault,
    output logic                       svc_valid,
    output logic [$clog2(NUM_REQ)-1:0] svc_id,
    output logic                       svc_preempt,
    input  logic                       svc_ready,
    input  logic                       svc_done,
    output logic [NUM_REQ-1:0]         pending,
    output logic                       busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int NI = NUM_REQ + 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, OFFER, SERVING, HOLDOFF, FAULT} state_t;

    logic [NI-1:0] s1_q, s2_q, db_q, dbp_q, rise;
    logic [DW-1:0] cnt_q [NI];

    state_t            st_q, st_d;
    logic [IW-1:0]     sel_q, sel_d, lg_q, lg_d, rr, idx;
    logic              selp_q, selp_d, ppend_q, ppend_d, clrp;
    logic [NUM_REQ-1:0] pend_q, pend_d, clr;
    logic [HW-1:0]     hcnt_q, hcnt_d;

    // Bit NUM_REQ of the conditioning pipeline carries the preempt input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q  <= '0;
            s2_q  <= '0;
            db_q  <= '0;
            dbp_q <= '0;
            for (int i = 0; i < NI; i++) cnt_q[i] <= '0;
        end else begin
            s1_q  <= {preempt_raw, req_raw};
            s2_q  <= s1_q;
            dbp_q <= db_q;
            for (int i = 0; i < NI; i++) begin
                if (s2_q[i] != db_q[i]) begin
                    if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                        db_q[i]  <= s2_q[i];
                        cnt_q[i] <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    assign rise = db_q & ~dbp_q;

    always_comb begin
        rr  = '0;
        idx = '0;
        // Descending scan so the nearest set bit after last_grant is written last.
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IW'((int'(lg_q) + k) % NUM_REQ);
            if (pend_q[idx]) rr = idx;
        end
    end

    always_comb begin
        st_d   = st_q;
        sel_d  = sel_q;
        selp_d = selp_q;
        lg_d   = lg_q;
        hcnt_d = '0;
        clr    = '0;
        clrp   = 1'b0;
        case (st_q)
            IDLE: begin
                if (ppend_q || |pend_q) begin
                    st_d   = OFFER;
                    selp_d = ppend_q;
                    sel_d  = ppend_q ? '0 : rr;
                end
            end
            OFFER: if (svc_ready) st_d = SERVING;
            SERVING: begin
                if (svc_done && !fault) begin
                    st_d = HOLDOFF;
                    if (selp_q) begin
                        clrp = 1'b1;
                    end else begin
                        clr[sel_q] = 1'b1;
                        lg_d       = sel_q;
                    end
                end
            end
            HOLDOFF: begin
                hcnt_d = hcnt_q + 1'b1;
                if (ppend_q) begin
                    st_d   = OFFER;
                    selp_d = 1'b1;
                    sel_d  = '0;
                end else if (hcnt_q == HW'(HOLDOFF_CYCLES - 1)) begin
                    st_d = IDLE;
                end
            end
            FAULT:   st_d = HOLDOFF;
            default: st_d = IDLE;
        endcase
        if (fault) st_d = FAULT;
        pend_d  = (pend_q & ~clr) | rise[NUM_REQ-1:0];
        ppend_d = (ppend_q & ~clrp) | rise[NUM_REQ];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q    <= IDLE;
            sel_q   <= '0;
            selp_q  <= 1'b0;
            lg_q    <= IW'(NUM_REQ - 1);
            pend_q  <= '0;
            ppend_q <= 1'b0;
            hcnt_q  <= '0;
        end else begin
            st_q    <= st_d;
            sel_q   <= sel_d;
            selp_q  <= selp_d;
            lg_q    <= lg_d;
            pend_q  <= pend_d;
            ppend_q <= ppend_d;
            hcnt_q  <= hcnt_d;
        end
    end

    assign svc_valid   = st_q == OFFER;
    assign svc_id      = sel_q;
    assign svc_preempt = selp_q;
    assign busy        = st_q == SERVING;
    assign pending     = pend_q;
endmodule

// File: tb/tb_intersection_request_scheduler.sv
// tb_intersection_request_scheduler: directed scenarios plus randomized rounds checked
// against a round-robin/preempt reference model.
module tb_intersection_request_scheduler;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req_raw = '0;
    logic       preempt_raw = 1'b0, fault = 1'b0, svc_ready = 1'b0, svc_done = 1'b0;
    logic       svc_valid, svc_preempt, busy;
    logic [1:0] svc_id;
    logic [3:0] pending;
    int         checks = 0, failures = 0;
    logic [3:0] mp;
    int         lg, e;
    logic       p;

    intersection_request_scheduler #(.NUM_REQ(4), .DEBOUNCE_CYCLES(4), .HOLDOFF_CYCLES(8)) dut (
        .clk(clk), .reset_n(reset_n), .req_raw(req_raw), .preempt_raw(preempt_raw), .fault(fault),
        .svc_valid(svc_valid), .svc_id(svc_id), .svc_preempt(svc_preempt), .svc_ready(svc_ready),
        .svc_done(svc_done), .pending(pending), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_offer(input logic [1:0] eid, input logic ep);
        int w = 0;
        while (!svc_valid && w < 200) begin
            tick();
            w++;
        end
        chk("offer_seen", 32'(svc_valid), 1);
        chk("offer_id", 32'(svc_id), 32'(eid));
        chk("offer_pre", 32'(svc_preempt), 32'(ep));
    endtask

    task automatic serve(input logic [1:0] eid, input logic ep, input int rd, input int dd);
        wait_offer(eid, ep);
        repeat (rd) begin
            tick();
            chk("offer_hold", 32'({svc_valid, svc_preempt, svc_id}), 32'({1'b1, ep, eid}));
        end
        svc_ready = 1'b1;
        tick();
        svc_ready = 1'b0;
        chk("serve_busy", 32'(busy), 1);
        chk("serve_valid_drop", 32'(svc_valid), 0);
        tick(dd);
        svc_done = 1'b1;
        tick();
        svc_done = 1'b0;
        chk("done_busy", 32'(busy), 0);
    endtask

    function automatic int rr_pick(input logic [3:0] m, input int l);
        for (int k = 1; k <= 4; k++) if (m[(l + k) % 4]) return (l + k) % 4;
        return 0;
    endfunction

    initial begin
        tick(3);
        reset_n = 1'b1;
        tick();
        chk("reset_outs", 32'({svc_valid, svc_preempt, svc_id, busy, pending}), 0);

        // async reset pulse while an offer is up
        req_raw = 4'b0001;
        tick(9);
        chk("pre_reset_offer", 32'(svc_valid), 1);
        req_raw = 4'b0000;
        reset_n = 1'b0;
        #1;
        chk("async_reset_outs", 32'({svc_valid, svc_preempt, svc_id, busy, pending}), 0);
        tick(2);
        reset_n = 1'b1;
        tick();

        // bouncing input never settles long enough
        for (int r = 0; r < 5; r++) begin
            req_raw = 4'b0100;
            tick(2);
            req_raw = 4'b0000;
            tick();
            chk("glitch_pending", 32'(pending), 0);
        end
        tick(3);
        req_raw = 4'b0100;
        tick(6);
        chk("latency_early", 32'(pending), 0);
        tick();
        chk("latency_exact", 32'(pending), 4'b0100);

        // offer held stable while ready is low
        for (int r = 0; r < 5; r++) begin
            tick();
            chk("hold_offer", 32'({svc_valid, svc_id}), 32'({1'b1, 2'd2}));
        end
        svc_ready = 1'b1;
        tick();
        svc_ready = 1'b0;
        chk("hs_busy", 32'(busy), 1);
        req_raw = 4'b0110;
        tick(8);
        chk("serving_pending", 32'(pending), 4'b0110);
        chk("serving_busy", 32'(busy), 1);
        svc_done = 1'b1;
        tick();
        svc_done = 1'b0;
        chk("done_clear", 32'(pending), 4'b0010);
        for (int r = 0; r < 8; r++) begin
            tick();
            chk("holdoff_quiet", 32'(svc_valid), 0);
        end
        tick();
        chk("holdoff_end", 32'({svc_valid, svc_id}), 32'({1'b1, 2'd1}));
        serve(2'd1, 1'b0, 0, 1);

        // round robin
        req_raw = 4'b0000;
        tick(8);
        req_raw = 4'b0001;
        tick(8);
        serve(2'd0, 1'b0, 0, 0);
        req_raw = 4'b0000;
        tick(8);
        req_raw = 4'b1011;
        tick(8);
        chk("rr_pending", 32'(pending), 4'b1011);
        serve(2'd1, 1'b0, 0, 0);
        chk("rr_after1", 32'(pending), 4'b1001);
        serve(2'd3, 1'b0, 0, 0);
        chk("rr_after3", 32'(pending), 4'b0001);
        serve(2'd0, 1'b0, 0, 0);
        chk("rr_after0", 32'(pending), 4'b0000);
        req_raw = 4'b0000;
        tick(8);
        req_raw = 4'b0010;
        tick(8);
        serve(2'd1, 1'b0, 0, 0);

        // preempt during SERVING bypasses hold-off
        req_raw = 4'b0000;
        tick(8);
        req_raw = 4'b0010;
        wait_offer(2'd1, 1'b0);
        svc_ready = 1'b1;
        tick();
        svc_ready = 1'b0;
        preempt_raw = 1'b1;
        tick(8);
        chk("pre_serving_busy", 32'(busy), 1);
        svc_done = 1'b1;
        tick();
        svc_done = 1'b0;
        tick();
        chk("pre_bypass", 32'({svc_valid, svc_preempt, svc_id}), 32'({1'b1, 1'b1, 2'd0}));
        serve(2'd0, 1'b1, 0, 0);

        // preempt during OFFER waits for the handshake
        preempt_raw = 1'b0;
        req_raw = 4'b1000;
        wait_offer(2'd3, 1'b0);
        preempt_raw = 1'b1;
        for (int r = 0; r < 9; r++) begin
            tick();
            chk("pre_offer_hold", 32'({svc_valid, svc_preempt, svc_id}), 32'({1'b1, 1'b0, 2'd3}));
        end
        svc_ready = 1'b1;
        tick();
        svc_ready = 1'b0;
        svc_done = 1'b1;
        tick();
        svc_done = 1'b0;
        tick();
        chk("pre_bypass2", 32'({svc_valid, svc_preempt, svc_id}), 32'({1'b1, 1'b1, 2'd0}));
        serve(2'd0, 1'b1, 0, 0);
        preempt_raw = 1'b0;

        // fault during SERVING keeps the request pending
        req_raw = 4'b0000;
        tick(8);
        req_raw = 4'b0001;
        wait_offer(2'd0, 1'b0);
        svc_ready = 1'b1;
        tick();
        svc_ready = 1'b0;
        fault = 1'b1;
        tick();
        chk("fault_outs", 32'({svc_valid, busy, pending}), 32'({1'b0, 1'b0, 4'b0001}));
        tick(3);
        chk("fault_hold", 32'({svc_valid, busy, pending}), 32'({1'b0, 1'b0, 4'b0001}));
        fault = 1'b0;
        tick();
        for (int r = 0; r < 8; r++) begin
            tick();
            chk("fault_holdoff", 32'(svc_valid), 0);
        end
        tick();
        chk("fault_reoffer", 32'({svc_valid, svc_id}), 32'({1'b1, 2'd0}));
        serve(2'd0, 1'b0, 0, 0);

        // done coinciding with a new edge on the same request
        req_raw = 4'b0000;
        tick(8);
        req_raw = 4'b0100;
        wait_offer(2'd2, 1'b0);
        req_raw = 4'b0000;
        svc_ready = 1'b1;
        tick();
        svc_ready = 1'b0;
        tick(8);
        req_raw = 4'b0100;
        tick(6);
        svc_done = 1'b1;
        tick();
        svc_done = 1'b0;
        chk("set_wins", 32'(pending), 4'b0100);
        serve(2'd2, 1'b0, 0, 0);
        chk("set_wins_served", 32'(pending), 0);
        tick(12);
        svc_done = 1'b1;
        tick();
        svc_done = 1'b0;
        chk("idle_done", 32'({svc_valid, busy, pending}), 0);

        // randomized rounds against the reference model
        lg = 2;
        mp = '0;
        for (int r = 0; r < 8; r++) begin
            req_raw = 4'b0000;
            preempt_raw = 1'b0;
            tick(8);
            mp = 4'($urandom_range(1, 15));
            p = ($urandom_range(0, 2) == 0);
            req_raw = mp;
            preempt_raw = p;
            tick(8);
            chk("rnd_pending", 32'(pending), 32'(mp));
            if (p) serve(2'd0, 1'b1, $urandom_range(0, 3), $urandom_range(0, 3));
            while (mp != 0) begin
                e = rr_pick(mp, lg);
                serve(2'(e), 1'b0, $urandom_range(0, 3), $urandom_range(0, 3));
                mp[e] = 1'b0;
                lg = e;
                chk("rnd_cleared", 32'(pending), 32'(mp));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
